// File: rtl/hdmi_tx_sequencer.sv
// HDMI/DVI transmit bring-up sequencer and video timing generator.
// Qualifies PLL lock, holds the TMDS transmitter in reset, runs one blank frame,
// then produces HS/VS/VDE and pixel coordinates. Every output is registered one
// cycle behind the h/v counter value it decodes.
// Optional build macro HDMI_SEQ_TESTPAT_EN adds RGB_o carrying 8 vertical colour bars.
module hdmi_tx_sequencer #(
  parameter int unsigned H_ACTIVE  = 1280,
  parameter int unsigned H_FP      = 110,
  parameter int unsigned H_SYNC    = 40,
  parameter int unsigned H_BP      = 220,
  parameter int unsigned V_ACTIVE  = 720,
  parameter int unsigned V_FP      = 5,
  parameter int unsigned V_SYNC    = 5,
  parameter int unsigned V_BP      = 20,
  parameter bit          HS_POL    = 1'b1,
  parameter bit          VS_POL    = 1'b1,
  parameter int unsigned LOCK_WAIT = 1024,
  parameter int unsigned RST_HOLD  = 16
) (
  input  logic        PCLKX1_i,
  input  logic        RSTn_i,
  input  logic        PLL_LOCK_i,
  input  logic        EN_i,
  output logic        TX_RSTn_o,
  output logic        VS_o,
  output logic        HS_o,
  output logic        VDE_o,
  output logic [11:0] X_o,
  output logic [11:0] Y_o,
  output logic        FRAME_START_o,
  output logic [2:0]  STATE_o
`ifdef HDMI_SEQ_TESTPAT_EN
  ,
  output logic [23:0] RGB_o
`endif
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // 13-bit thresholds so a sync end of exactly 4096 still compares correctly
  localparam logic [12:0] HActive  = 13'(H_ACTIVE);
  localparam logic [12:0] HSyncBeg = 13'(H_ACTIVE + H_FP);
  localparam logic [12:0] HSyncEnd = 13'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] HLast    = 12'(H_TOTAL - 1);
  localparam logic [12:0] VActive  = 13'(V_ACTIVE);
  localparam logic [12:0] VSyncBeg = 13'(V_ACTIVE + V_FP);
  localparam logic [12:0] VSyncEnd = 13'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [11:0] VLast    = 12'(V_TOTAL - 1);

  localparam int unsigned LockW = $clog2(LOCK_WAIT + 1);
  localparam int unsigned HoldW = $clog2(RST_HOLD + 1);
  localparam logic [LockW-1:0] LockLast = LockW'(LOCK_WAIT - 1);
  localparam logic [HoldW-1:0] HoldLast = HoldW'(RST_HOLD - 1);

  if (H_TOTAL > 4096) begin : gen_h_total_chk
    $error("hdmi_tx_sequencer: H_TOTAL exceeds 4096");
  end
  if (V_TOTAL > 4096) begin : gen_v_total_chk
    $error("hdmi_tx_sequencer: V_TOTAL exceeds 4096");
  end
  if (LOCK_WAIT < 1 || RST_HOLD < 1) begin : gen_wait_chk
    $error("hdmi_tx_sequencer: LOCK_WAIT and RST_HOLD must be at least 1");
  end

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StLockWait = 3'd1,
    StTxRst    = 3'd2,
    StBlank    = 3'd3,
    StActive   = 3'd4
  } state_e;

  state_e           state_q;
  logic [LockW-1:0] lock_cnt_q;
  logic [HoldW-1:0] hold_cnt_q;
  logic [11:0]      h_q, v_q;
  logic             tx_rstn_q, vs_q, hs_q, vde_q, fs_q;
  logic [11:0]      x_q, y_q;

  logic running, h_last, v_last, frame_end, hs_act, vs_act, de_act;

  // Decode the current counter position; results are registered below
  always_comb begin
    running   = (state_q == StBlank) || (state_q == StActive);
    h_last    = (h_q == HLast);
    v_last    = (v_q == VLast);
    frame_end = h_last && v_last;
    hs_act    = running && ({1'b0, h_q} >= HSyncBeg) && ({1'b0, h_q} < HSyncEnd);
    vs_act    = running && ({1'b0, v_q} >= VSyncBeg) && ({1'b0, v_q} < VSyncEnd);
    de_act    = (state_q == StActive) && ({1'b0, h_q} < HActive) && ({1'b0, v_q} < VActive);
  end

`ifdef HDMI_SEQ_TESTPAT_EN
  localparam int unsigned BarW = H_ACTIVE / 8;

  logic [2:0]  bar_idx;
  logic [23:0] bar_rgb;
  logic [23:0] rgb_q;

  // Colour bar lookup: bar index is the number of bar boundaries at or left of h
  always_comb begin
    bar_idx = 3'd0;
    for (int unsigned i = 1; i < 8; i++) begin
      if ({1'b0, h_q} >= 13'(i * BarW)) bar_idx = 3'(i);
    end
    case (bar_idx)
      3'd0:    bar_rgb = 24'hFFFFFF;
      3'd1:    bar_rgb = 24'hFFFF00;
      3'd2:    bar_rgb = 24'h00FFFF;
      3'd3:    bar_rgb = 24'h00FF00;
      3'd4:    bar_rgb = 24'hFF00FF;
      3'd5:    bar_rgb = 24'hFF0000;
      3'd6:    bar_rgb = 24'h0000FF;
      default: bar_rgb = 24'h000000;
    endcase
  end

  // Pattern pixel, registered alongside VDE so it shares its alignment
  always_ff @(posedge PCLKX1_i or negedge RSTn_i) begin
    if (!RSTn_i) rgb_q <= 24'h000000;
    else         rgb_q <= de_act ? bar_rgb : 24'h000000;
  end

  assign RGB_o = rgb_q;
`endif

  // Sequencer FSM, h/v counters and registered timing outputs
  always_ff @(posedge PCLKX1_i or negedge RSTn_i) begin
    if (!RSTn_i) begin
      state_q    <= StIdle;
      lock_cnt_q <= '0;
      hold_cnt_q <= '0;
      h_q        <= '0;
      v_q        <= '0;
      tx_rstn_q  <= 1'b0;
      vs_q       <= ~VS_POL;
      hs_q       <= ~HS_POL;
      vde_q      <= 1'b0;
      fs_q       <= 1'b0;
      x_q        <= '0;
      y_q        <= '0;
    end else begin
      vde_q     <= de_act;
      hs_q      <= hs_act ? HS_POL : ~HS_POL;
      vs_q      <= vs_act ? VS_POL : ~VS_POL;
      fs_q      <= running && (h_q == 12'd0) && (v_q == 12'd0);
      x_q       <= h_q;
      y_q       <= v_q;
      // Stays high through the lock-loss edge, drops once the state reads idle
      tx_rstn_q <= running;

      unique case (state_q)
        StIdle: begin
          lock_cnt_q <= '0;
          if (PLL_LOCK_i) state_q <= StLockWait;
        end
        StLockWait: begin
          if (!PLL_LOCK_i) begin
            lock_cnt_q <= '0;
          end else if (lock_cnt_q == LockLast) begin
            state_q    <= StTxRst;
            hold_cnt_q <= '0;
          end else begin
            lock_cnt_q <= lock_cnt_q + 1'b1;
          end
        end
        StTxRst: begin
          if (!PLL_LOCK_i) begin
            state_q <= StIdle;
          end else if (hold_cnt_q == HoldLast) begin
            state_q   <= StBlank;
            tx_rstn_q <= 1'b1;
            h_q       <= '0;
            v_q       <= '0;
          end else begin
            hold_cnt_q <= hold_cnt_q + 1'b1;
          end
        end
        StBlank, StActive: begin
          if (!PLL_LOCK_i) begin
            state_q <= StIdle;
            h_q     <= '0;
            v_q     <= '0;
          end else begin
            if (h_last) begin
              h_q <= '0;
              v_q <= v_last ? 12'd0 : v_q + 12'd1;
            end else begin
              h_q <= h_q + 12'd1;
            end
            // Mode changes only between frames so no partial frame is ever sent
            if (frame_end) state_q <= EN_i ? StActive : StBlank;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign TX_RSTn_o     = tx_rstn_q;
  assign VS_o          = vs_q;
  assign HS_o          = hs_q;
  assign VDE_o         = vde_q;
  assign X_o           = x_q;
  assign Y_o           = y_q;
  assign FRAME_START_o = fs_q;
  assign STATE_o       = state_q;

endmodule

// File: tb/tb_hdmi_tx_sequencer.sv
// Self-checking bench for hdmi_tx_sequencer using a small video timing.
// A frame-position model predicts every output each cycle; directed scenarios
// add hand-computed expectations for bring-up delay, frame content and lock loss.
module tb_hdmi_tx_sequencer;

  localparam int HA = 16, HFP = 2, HSY = 2, HBP = 2;
  localparam int VA = 8, VFP = 1, VSY = 1, VBP = 1;
  localparam int LW = 8, RH = 4;
  localparam int HT = HA + HFP + HSY + HBP;  // 22
  localparam int VT = VA + VFP + VSY + VBP;  // 11
  localparam int FT = HT * VT;               // 242

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        lock = 1'b0;
  logic        en = 1'b0;
  logic        TX_RSTn_o, VS_o, HS_o, VDE_o, FRAME_START_o;
  logic [11:0] X_o, Y_o;
  logic [2:0]  STATE_o;
`ifdef HDMI_SEQ_TESTPAT_EN
  logic [23:0] RGB_o;
`endif

  hdmi_tx_sequencer #(
    .H_ACTIVE (HA),
    .H_FP     (HFP),
    .H_SYNC   (HSY),
    .H_BP     (HBP),
    .V_ACTIVE (VA),
    .V_FP     (VFP),
    .V_SYNC   (VSY),
    .V_BP     (VBP),
    .HS_POL   (1'b1),
    .VS_POL   (1'b1),
    .LOCK_WAIT(LW),
    .RST_HOLD (RH)
  ) dut (
    .PCLKX1_i     (clk),
    .RSTn_i       (rst_n),
    .PLL_LOCK_i   (lock),
    .EN_i         (en),
    .TX_RSTn_o    (TX_RSTn_o),
    .VS_o         (VS_o),
    .HS_o         (HS_o),
    .VDE_o        (VDE_o),
    .X_o          (X_o),
    .Y_o          (Y_o),
    .FRAME_START_o(FRAME_START_o),
    .STATE_o      (STATE_o)
`ifdef HDMI_SEQ_TESTPAT_EN
    ,
    .RGB_o        (RGB_o)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit cmp_on = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // State numbers follow the published status encoding; the frame is tracked as a
  // single linear position 0..FT-1 and h/v are derived from it arithmetically.
  int          m_st, m_lc, m_hc, m_pos;
  logic        e_tx, e_vde, e_hs, e_vs, e_fs;
  int          e_x, e_y, e_st;
  logic [23:0] e_rgb;
  logic [23:0] bars [8];

  initial begin : model
    int h, v, old;
    bit run;
    bars = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
             24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
    m_st = 0; m_lc = 0; m_hc = 0; m_pos = 0;
    e_tx = 0; e_vde = 0; e_hs = 0; e_vs = 0; e_fs = 0; e_x = 0; e_y = 0; e_st = 0;
    e_rgb = 24'h0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_st = 0; m_lc = 0; m_hc = 0; m_pos = 0;
        e_tx = 0; e_vde = 0; e_hs = 0; e_vs = 0; e_fs = 0; e_x = 0; e_y = 0; e_st = 0;
        e_rgb = 24'h0;
      end else begin
        h   = m_pos % HT;
        v   = m_pos / HT;
        run = (m_st == 3) || (m_st == 4);
        e_vde = (m_st == 4) && (h < HA) && (v < VA);
        e_hs  = run && (h >= HA + HFP) && (h < HA + HFP + HSY);
        e_vs  = run && (v >= VA + VFP) && (v < VA + VFP + VSY);
        e_fs  = run && (m_pos == 0);
        e_x   = h;
        e_y   = v;
        e_rgb = e_vde ? bars[h / (HA / 8)] : 24'h0;
        old   = m_st;
        case (m_st)
          0: if (lock) begin m_st = 1; m_lc = 0; end
          1: begin
            if (!lock) m_lc = 0;
            else if (m_lc == LW - 1) begin m_st = 2; m_hc = 0; end
            else m_lc++;
          end
          2: begin
            if (!lock) m_st = 0;
            else if (m_hc == RH - 1) begin m_st = 3; m_pos = 0; end
            else m_hc++;
          end
          default: begin
            if (!lock) begin
              m_st = 0; m_pos = 0;
            end else begin
              if (m_pos == FT - 1) m_st = en ? 4 : 3;
              m_pos = (m_pos + 1) % FT;
            end
          end
        endcase
        e_tx = (old == 3) || (old == 4) || (m_st == 3);
        e_st = m_st;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin : compare
    forever begin
      @(negedge clk);
      if (rst_n && cmp_on) begin
        check("tx_rstn", TX_RSTn_o, e_tx);
        check("vde", VDE_o, e_vde);
        check("hs", HS_o, e_hs);
        check("vs", VS_o, e_vs);
        check("frame_start", FRAME_START_o, e_fs);
        check("state", STATE_o, e_st);
        if (e_vde) begin
          check("x", X_o, e_x);
          check("y", Y_o, e_y);
        end
`ifdef HDMI_SEQ_TESTPAT_EN
        check("rgb", RGB_o, e_rgb);
        if (VDE_o && X_o == 12'd0) check("rgb_x0", RGB_o, 24'hFFFFFF);
        if (VDE_o && X_o == 12'd1) check("rgb_x1", RGB_o, 24'hFFFFFF);
        if (VDE_o && X_o == 12'd2) check("rgb_x2", RGB_o, 24'hFFFF00);
        if (VDE_o && X_o == 12'd15) check("rgb_x15", RGB_o, 24'h000000);
        if (!VDE_o) check("rgb_blank", RGB_o, 24'h000000);
`endif
      end
    end
  end

  // Count one frame starting at a negedge where FRAME_START_o is high
  task automatic measure_frame(input bit drop_en, output int de, output int hs, output int vs,
                               output int len, output int runs);
    logic prev_vde;
    de = 0; hs = 0; vs = 0; len = 0; runs = 0; prev_vde = 1'b0;
    do begin
      if (VDE_o) de++;
      if (VDE_o && !prev_vde) runs++;
      prev_vde = VDE_o;
      if (HS_o) hs++;
      if (VS_o) vs++;
      if (drop_en && VDE_o && X_o == 12'd5 && Y_o == 12'd3) en = 1'b0;
      len++;
      @(negedge clk);
    end while (FRAME_START_o !== 1'b1 && len < 400);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin : stim
    int n, de, hs, vs, len, runs;
    repeat (3) @(negedge clk);
    check("rst_tx_rstn", TX_RSTn_o, 0);
    check("rst_vde", VDE_o, 0);
    check("rst_hs", HS_o, 0);
    check("rst_vs", VS_o, 0);
    check("rst_frame_start", FRAME_START_o, 0);
    check("rst_state", STATE_o, 0);
    check("rst_x", X_o, 0);
    check("rst_y", Y_o, 0);
    cmp_on = 1'b1;

    #2 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_without_lock", STATE_o, 0);

    // Lock glitch during qualification restarts the count
    lock = 1'b1;
    n = 0;
    while (STATE_o !== 3'd1 && n < 10) begin @(negedge clk); n++; end
    check("glitch_lockwait_entry", STATE_o, 1);
    repeat (5) @(negedge clk);
    lock = 1'b0;
    @(negedge clk);
    lock = 1'b1;
    n = 6;
    while (TX_RSTn_o !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    check("glitch_release_delay", n, 18);

    // Clean bring-up from reset with lock already high
    @(negedge clk);
    #2 rst_n = 1'b0;
    en = 1'b1;
    @(negedge clk);
    #2 rst_n = 1'b1;
    n = 0;
    while (STATE_o !== 3'd1 && n < 10) begin @(negedge clk); n++; end
    check("lockwait_entry", STATE_o, 1);
    n = 0;
    while (TX_RSTn_o !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    check("release_delay", n, 12);

    n = 0;
    while (FRAME_START_o !== 1'b1 && n < 300) begin @(negedge clk); n++; end
    check("first_frame_start_seen", FRAME_START_o, 1);

    measure_frame(1'b0, de, hs, vs, len, runs);
    check("blank_frame_de", de, 0);
    check("blank_frame_len", len, FT);
    check("blank_frame_hs", hs, 22);
    check("blank_frame_vs", vs, 22);

    measure_frame(1'b0, de, hs, vs, len, runs);
    check("active_frame_de", de, 128);
    check("active_frame_lines", runs, 8);
    check("active_frame_len", len, 242);

    // EN drop mid-frame: this frame still completes, the next is blank
    measure_frame(1'b1, de, hs, vs, len, runs);
    check("en_drop_frame_de", de, 128);
    check("en_drop_frame_len", len, 242);
    measure_frame(1'b0, de, hs, vs, len, runs);
    check("after_drop_frame_de", de, 0);

    // Re-enable, then lose lock in the middle of an active line
    en = 1'b1;
    n = 0;
    while (!(VDE_o === 1'b1 && X_o == 12'd3) && n < 700) begin @(negedge clk); n++; end
    check("active_line_found", VDE_o, 1);
    lock = 1'b0;
    @(negedge clk);
    check("lockloss_state", STATE_o, 0);
    @(negedge clk);
    check("lockloss_vde", VDE_o, 0);
    check("lockloss_tx_rstn", TX_RSTn_o, 0);
    check("lockloss_state_hold", STATE_o, 0);
    repeat (5) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
